// File: rtl/phase_sequencer_pkg.sv
// ============================================================================
// sequencer_defs : shared state encoding and widths for phase_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package sequencer_defs;

   localparam int PHASE_W  = 3;
   localparam int ICOUNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   typedef logic [PHASE_W-1:0]  phase_t;
   typedef logic [ICOUNT_W-1:0] icount_t;

   function automatic phase_t to_phase(input int unsigned n);
      return phase_t'(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/phase_sequencer_button_sync.sv
// ============================================================================
// button_sync : synchronizer plus falling-edge detector for an active-low
//               push button that is asynchronous to clk
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic exec_i,
   output logic level_o,
   output logic press_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_q;
   logic                   press_q;

   // Reset loads "released" everywhere so deasserting rst cannot fake a press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= '1;
         level_q <= 1'b1;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], exec_i};
         level_q <= sync_q[SYNC_STAGES-1];
         press_q <= level_q & ~sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// phase_sequencer : IDLE/RUN/HALTED instruction phase sequencer driven by a
//                   push button, with single-step, halt and instruction count
// Revision: 1.0
// ============================================================================
`default_nettype none

module phase_sequencer
   import sequencer_defs::*;
#(
   parameter int PHASES      = 5,
   parameter int PC_PHASE    = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                exec,
   input  logic                step,
   input  logic                hlt,
   output logic [PHASE_W-1:0]  phase,
   output logic                pc_e,
   output logic                running,
   output logic                halted,
   output logic [ICOUNT_W-1:0] icount
);

   localparam phase_t c_last_phase = to_phase(PHASES);
   localparam phase_t c_pc_phase   = to_phase(PC_PHASE);

   state_e  state_q,  state_d;
   phase_t  phase_q,  phase_d;
   icount_t icount_q, icount_d;
   logic    stop_q,   stop_d;
   logic    hlt_q,    hlt_d;
   logic    pc_e_q,   pc_e_d;

   logic    w_btn_level;
   logic    w_btn_press;
   logic    w_press;
   logic    w_stop_any;
   logic    w_hlt_any;

   button_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_button_sync (
      .clk     (clk),
      .rst     (rst),
      .exec_i  (exec),
      .level_o (w_btn_level),
      .press_o (w_btn_press)
   );

   // The pulse is emitted together with the low level it detected.
   assign w_press = w_btn_press & ~w_btn_level;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      icount_d   = icount_q;
      stop_d     = stop_q;
      hlt_d      = hlt_q;
      w_stop_any = stop_q | w_press;
      w_hlt_any  = hlt_q | hlt;

      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (w_press) begin
               state_d = ST_RUN;
               phase_d = phase_t'(1);
            end
         end
         ST_RUN: begin
            if (phase_q == c_last_phase) begin
               // Boundary: requests seen during this instruction, including
               // this very cycle, decide what follows; halt wins over stop.
               icount_d = icount_q + icount_t'(1);
               stop_d   = 1'b0;
               hlt_d    = 1'b0;
               if (w_hlt_any) begin
                  state_d = ST_HALTED;
                  phase_d = '0;
               end else if (w_stop_any || step) begin
                  state_d = ST_IDLE;
                  phase_d = '0;
               end else begin
                  phase_d = phase_t'(1);
               end
            end else begin
               phase_d = phase_q + phase_t'(1);
               stop_d  = w_stop_any;
               hlt_d   = w_hlt_any;
            end
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = '0;
            stop_d  = 1'b0;
            hlt_d   = 1'b0;
         end
      endcase

      pc_e_d = (state_d == ST_RUN) && (phase_d == c_pc_phase);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         phase_q  <= '0;
         icount_q <= '0;
         stop_q   <= 1'b0;
         hlt_q    <= 1'b0;
         pc_e_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         icount_q <= icount_d;
         stop_q   <= stop_d;
         hlt_q    <= hlt_d;
         pc_e_q   <= pc_e_d;
      end
   end

   assign phase   = phase_q;
   assign pc_e    = pc_e_q;
   assign running = (state_q == ST_RUN);
   assign halted  = (state_q == ST_HALTED);
   assign icount  = icount_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// tb_phase_sequencer : directed vector table plus hand-written sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic        rst, exec, step, hlt;
   logic [2:0]  phase;
   logic        pc_e, running, halted;
   logic [15:0] icount;

   // Single-phase instance, used to reach the icount wrap quickly
   logic        rst_w, exec_w;
   logic [2:0]  phase_w;
   logic        pc_e_w, running_w, halted_w;
   logic [15:0] icount_w;

   phase_sequencer #(.PHASES(5), .PC_PHASE(5), .SYNC_STAGES(2)) u_dut (
      .clk (clk), .rst (rst), .exec (exec), .step (step), .hlt (hlt),
      .phase (phase), .pc_e (pc_e), .running (running), .halted (halted),
      .icount (icount)
   );

   phase_sequencer #(.PHASES(1), .PC_PHASE(1), .SYNC_STAGES(2)) u_wrap (
      .clk (clk), .rst (rst_w), .exec (exec_w), .step (1'b0), .hlt (1'b0),
      .phase (phase_w), .pc_e (pc_e_w), .running (running_w), .halted (halted_w),
      .icount (icount_w)
   );

   typedef struct {
      logic        r, e, s, h;
      logic [2:0]  ph;
      logic        pc, run, hal;
      logic [15:0] ic;
   } vec_t;

   vec_t vq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, e, s, h, input logic [2:0] ph,
                      input logic pc, run, hal, input logic [15:0] ic);
      vq.push_back('{r: r, e: e, s: s, h: h, ph: ph, pc: pc, run: run, hal: hal, ic: ic});
   endtask

   // Press exec and return the number of edges until phase leaves 0 (0 = timeout)
   task automatic press_start(output int n);
      n    = 0;
      exec = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (phase != 3'd0) begin
            n = c;
            break;
         end
      end
      exec = 1'b1;
   endtask

   initial begin
      int n;
      rst = 1'b0; exec = 1'b1; step = 1'b0; hlt = 1'b0;
      rst_w = 1'b0; exec_w = 1'b1;

      //    r  e  s  h  ph  pc run hal ic
      add(0, 1, 0, 0, 0, 0, 0, 0, 0);   // v0  reset
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);   // v1  first cycle after release
      add(1, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);   // v3  press held low
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 1, 0, 0);   // v6  phase 1
      add(1, 0, 0, 0, 2, 0, 1, 0, 0);
      add(1, 1, 0, 0, 3, 0, 1, 0, 0);
      add(1, 1, 0, 0, 4, 0, 1, 0, 0);
      add(1, 1, 0, 0, 5, 1, 1, 0, 0);
      add(1, 1, 0, 0, 1, 0, 1, 0, 1);   // v11 continuous run
      add(1, 1, 0, 0, 2, 0, 1, 0, 1);
      add(1, 1, 0, 0, 3, 0, 1, 0, 1);
      add(1, 1, 0, 0, 4, 0, 1, 0, 1);
      add(1, 0, 0, 0, 5, 1, 1, 0, 1);   // v15 second press, event in phase 2
      add(1, 0, 0, 0, 1, 0, 1, 0, 2);
      add(1, 0, 0, 0, 2, 0, 1, 0, 2);
      add(1, 0, 0, 0, 3, 0, 1, 0, 2);
      add(1, 0, 0, 0, 4, 0, 1, 0, 2);
      add(1, 1, 0, 0, 5, 1, 1, 0, 2);
      add(1, 1, 0, 0, 0, 0, 0, 0, 3);   // v21 stopped to IDLE
      add(1, 1, 0, 0, 0, 0, 0, 0, 3);
      add(1, 0, 0, 0, 0, 0, 0, 0, 3);   // v23 restart
      add(1, 0, 0, 0, 0, 0, 0, 0, 3);
      add(1, 0, 0, 0, 0, 0, 0, 0, 3);
      add(1, 0, 0, 0, 1, 0, 1, 0, 3);
      add(1, 1, 0, 0, 2, 0, 1, 0, 3);
      add(1, 0, 0, 0, 3, 0, 1, 0, 3);   // v28 press, event lands in phase 5
      add(1, 0, 0, 1, 4, 0, 1, 0, 3);   // v29 hlt sampled in phase 3
      add(1, 0, 0, 0, 5, 1, 1, 0, 3);
      add(1, 1, 0, 0, 0, 0, 0, 1, 4);   // v31 halted
      add(1, 1, 0, 0, 0, 0, 0, 1, 4);
      add(1, 0, 0, 0, 0, 0, 0, 1, 4);   // v33 resume from HALTED
      add(1, 0, 0, 0, 0, 0, 0, 1, 4);
      add(1, 0, 0, 0, 0, 0, 0, 1, 4);
      add(1, 1, 0, 0, 1, 0, 1, 0, 4);
      add(1, 1, 0, 0, 2, 0, 1, 0, 4);
      add(1, 1, 0, 0, 3, 0, 1, 0, 4);
      add(1, 1, 0, 0, 4, 0, 1, 0, 4);
      add(1, 1, 0, 0, 5, 1, 1, 0, 4);
      add(1, 1, 0, 0, 1, 0, 1, 0, 5);
      add(1, 1, 0, 0, 2, 0, 1, 0, 5);
      add(1, 1, 0, 0, 3, 0, 1, 0, 5);
      add(1, 1, 0, 0, 4, 0, 1, 0, 5);
      add(1, 1, 0, 0, 5, 1, 1, 0, 5);
      add(1, 1, 0, 1, 0, 0, 0, 1, 6);   // v46 hlt sampled in phase 5
      add(1, 1, 0, 0, 0, 0, 0, 1, 6);

      foreach (vq[i]) begin
         rst = vq[i].r; exec = vq[i].e; step = vq[i].s; hlt = vq[i].h;
         @(posedge clk); #1;
         chk($sformatf("vec%0d phase", i),   32'(phase),   32'(vq[i].ph));
         chk($sformatf("vec%0d pc_e", i),    32'(pc_e),    32'(vq[i].pc));
         chk($sformatf("vec%0d running", i), 32'(running), 32'(vq[i].run));
         chk($sformatf("vec%0d halted", i),  32'(halted),  32'(vq[i].hal));
         chk($sformatf("vec%0d icount", i),  32'(icount),  32'(vq[i].ic));
      end
      hlt = 1'b0;

      // Single-step: three presses, exactly five phases each, IDLE between
      step = 1'b1;
      for (int k = 0; k < 3; k++) begin
         press_start(n);
         chk($sformatf("step%0d start latency", k), 32'(n), 32'd4);
         chk($sformatf("step%0d phase1", k), 32'(phase), 32'd1);
         for (int p = 2; p <= 5; p++) begin
            @(posedge clk); #1;
            chk($sformatf("step%0d phase%0d", k, p), 32'(phase), 32'(p));
         end
         @(posedge clk); #1;
         chk($sformatf("step%0d end phase", k), 32'(phase), 32'd0);
         chk($sformatf("step%0d end running", k), 32'(running), 32'd0);
         chk($sformatf("step%0d end halted", k), 32'(halted), 32'd0);
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("step%0d idle phase", k), 32'(phase), 32'd0);
      end
      chk("step icount", 32'(icount), 32'd9);
      step = 1'b0;

      // Reset in the middle of an instruction
      press_start(n);
      chk("mid start latency", 32'(n), 32'd4);
      repeat (2) @(posedge clk);
      #1;
      chk("mid phase before reset", 32'(phase), 32'd3);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid reset phase", 32'(phase), 32'd0);
      chk("mid reset icount", 32'(icount), 32'd0);
      chk("mid reset pc_e", 32'(pc_e), 32'd0);
      chk("mid reset running", 32'(running), 32'd0);
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chk($sformatf("quiet%0d phase", c), 32'(phase), 32'd0);
         chk($sformatf("quiet%0d pc_e", c), 32'(pc_e), 32'd0);
         chk($sformatf("quiet%0d running", c), 32'(running), 32'd0);
      end
      chk("quiet icount", 32'(icount), 32'd0);

      // icount wrap on the single-phase instance
      rst_w  = 1'b1;
      exec_w = 1'b0;
      n      = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (phase_w != 3'd0) begin
            n = c;
            break;
         end
      end
      exec_w = 1'b1;
      chk("wrap start latency", 32'(n), 32'd4);
      chk("wrap start icount", 32'(icount_w), 32'd0);
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap icount ffff", 32'(icount_w), 32'hFFFF);
      chk("wrap pc_e", 32'(pc_e_w), 32'd1);
      chk("wrap running", 32'(running_w), 32'd1);
      @(posedge clk); #1;
      chk("wrap icount 0", 32'(icount_w), 32'h0000);
      chk("wrap phase", 32'(phase_w), 32'd1);
      rst_w = 1'b0;
      @(posedge clk); #1;
      chk("wrap reset phase", 32'(phase_w), 32'd0);
      chk("wrap reset pc_e", 32'(pc_e_w), 32'd0);
      chk("wrap reset halted", 32'(halted_w), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
